serial_subtractor: RTL

//   Multi-cycle, parametrised successor to the 1-bit full subtractor.

---
 rtl/serial_subtractor.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes diff = a - b - cin over WIDTH-bit unsigned
// operands, DIGIT bits per clock, LSB slice first. The borrow ripples between
// slices through a register; start/busy/done frame each operation.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Reject parameter sets that cannot be split into whole slices.
  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_subtractor: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;

  // One slice of the subtraction, one bit wider so the top bit is the borrow.
  logic [DIGIT:0]   slice;
  logic [DIGIT-1:0] slice_d;
  logic             slice_bo;
  logic [WIDTH-1:0] full_res;

  assign slice    = {1'b0, a_sh_q[DIGIT-1:0]} - {1'b0, b_sh_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, br_q};
  assign slice_d  = slice[DIGIT-1:0];
  assign slice_bo = slice[DIGIT];

  // Partial result: holds the slices already computed, MSB-aligned so that
  // the current slice completes the word when it enters from the top.
  generate
    if (DIGIT < WIDTH) begin : g_res
      logic [WIDTH-DIGIT-1:0] res_q, res_d;

      assign full_res = {slice_d, res_q};

      // Shift the new slice in from the MSB side while running.
      always_comb begin
        res_d = res_q;
        if (state_q == RUN) res_d = full_res[WIDTH-1:DIGIT];
      end

      // Partial-result register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) res_q <= '0;
        else     res_q <= res_d;
      end
    end else begin : g_nores
      // A single slice covers the whole word; nothing to accumulate.
      assign full_res = slice_d;
    end
  endgenerate

  // Next-state and datapath control: capture, per-slice shift, final commit.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d = a_sh_q >> DIGIT;
        b_sh_d = b_sh_q >> DIGIT;
        br_d   = slice_bo;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          diff_d   = full_res;
          borrow_d = slice_bo;
          zero_d   = (full_res == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and result registers; reset abandons any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;

endmodule
